// File: rtl/split_route_ctrl.sv
// split_route_ctrl: FIFO-buffered feeder for the 1-to-2 split stage.
// Each buffered packet is decoded into a route select (0 = local PE,
// 1 = next hop) and offered on independent data and control handshakes.
module split_route_ctrl #(
   parameter int WIDTH      = 16,
   parameter int ADDR_W     = 4,
   parameter int ADDR_LSB   = 12,
   parameter int LOCAL_ADDR = 0,
   parameter int DEPTH      = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [WIDTH-1:0]         in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_data_valid,
   input  logic                     out_data_ready,
   output logic [1:0]               out_ctrl,
   output logic                     out_ctrl_valid,
   input  logic                     out_ctrl_ready,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic {
      IDLE,
      ISSUE
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [WIDTH-1:0]  out_data_q, out_data_d;
   logic [1:0]        out_ctrl_q, out_ctrl_d;
   logic              dvalid_q, dvalid_d;
   logic              cvalid_q, cvalid_d;
   logic              ddone_q, ddone_d;
   logic              cdone_q, cdone_d;

   logic              push;
   logic              pop;
   logic [WIDTH-1:0]  head;
   logic              fifo_nonempty;

   function automatic logic [1:0] route_of(input logic [WIDTH-1:0] pkt);
      return (pkt[ADDR_LSB +: ADDR_W] == ADDR_W'(LOCAL_ADDR)) ? 2'd0 : 2'd1;
   endfunction

   assign in_ready       = rst_n && (count_q < DEPTH_C);
   assign push           = in_valid && in_ready;
   assign head           = mem_q[rd_ptr_q];
   // Only entries already stored count; a same-cycle push is not bypassed.
   assign fifo_nonempty  = (count_q != '0);

   assign out_data       = out_data_q;
   assign out_ctrl       = out_ctrl_q;
   assign out_data_valid = dvalid_q;
   assign out_ctrl_valid = cvalid_q;
   assign fifo_count     = count_q;

   // FIFO storage write; contents need no reset since pointers gate visibility.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

   // Pointer and occupancy next-state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
   end

   // Issue FSM: pop into the output registers and track per-channel completion.
   always_comb begin
      state_d    = state_q;
      out_data_d = out_data_q;
      out_ctrl_d = out_ctrl_q;
      dvalid_d   = dvalid_q;
      cvalid_d   = cvalid_q;
      ddone_d    = ddone_q;
      cdone_d    = cdone_q;
      pop        = 1'b0;

      case (state_q)
         IDLE: begin
            if (fifo_nonempty) begin
               pop        = 1'b1;
               out_data_d = head;
               out_ctrl_d = route_of(head);
               dvalid_d   = 1'b1;
               cvalid_d   = 1'b1;
               ddone_d    = 1'b0;
               cdone_d    = 1'b0;
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            // A ready seen while its valid is already low has no effect.
            ddone_d  = ddone_q | (dvalid_q & out_data_ready);
            cdone_d  = cdone_q | (cvalid_q & out_ctrl_ready);
            dvalid_d = dvalid_q & ~out_data_ready;
            cvalid_d = cvalid_q & ~out_ctrl_ready;
            if (ddone_d && cdone_d) begin
               if (fifo_nonempty) begin
                  pop        = 1'b1;
                  out_data_d = head;
                  out_ctrl_d = route_of(head);
                  dvalid_d   = 1'b1;
                  cvalid_d   = 1'b1;
                  ddone_d    = 1'b0;
                  cdone_d    = 1'b0;
               end else begin
                  dvalid_d = 1'b0;
                  cvalid_d = 1'b0;
                  state_d  = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         out_data_q <= '0;
         out_ctrl_q <= '0;
         dvalid_q   <= 1'b0;
         cvalid_q   <= 1'b0;
         ddone_q    <= 1'b0;
         cdone_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         out_data_q <= out_data_d;
         out_ctrl_q <= out_ctrl_d;
         dvalid_q   <= dvalid_d;
         cvalid_q   <= cvalid_d;
         ddone_q    <= ddone_d;
         cdone_q    <= cdone_d;
      end
   end

endmodule
